// File: rtl/riscv_mem_responder_pkg.sv
// Shared types and constants for the CPU-model memory responder.
package riscv_mem_pkg;
  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DEF_CNT_W  = 16;
endpackage

// File: rtl/riscv_mem_responder_if.sv
// Fetch, data, preload and status signals between the CPU model and the responder.
interface riscv_mem_if
  import riscv_mem_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic [31:0]      INSTR_ADDR;
  logic [31:0]      INSTR;
  logic             RD_EN;
  logic             WR_EN;
  logic [31:0]      DATA_ADDR;
  logic [31:0]      DATA_OUT;
  logic [31:0]      DATA_IN;
  logic             LOAD_EN;
  logic [31:0]      LOAD_ADDR;
  logic [31:0]      LOAD_DATA;
  logic             BUSY;
  logic             ERR_ALIGN;
  logic             ERR_RANGE;
  logic [CNT_W-1:0] RD_CNT;
  logic [CNT_W-1:0] WR_CNT;

  modport master (
    output INSTR_ADDR, RD_EN, WR_EN, DATA_ADDR, DATA_OUT, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    input  INSTR, DATA_IN, BUSY, ERR_ALIGN, ERR_RANGE, RD_CNT, WR_CNT
  );

  modport slave (
    input  INSTR_ADDR, RD_EN, WR_EN, DATA_ADDR, DATA_OUT, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    output INSTR, DATA_IN, BUSY, ERR_ALIGN, ERR_RANGE, RD_CNT, WR_CNT
  );
endinterface

// File: rtl/riscv_mem_responder_addr_chk.sv
// Byte address -> word index decode with range and alignment status.
module mem_addr_chk
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             in_range,
  output logic             aligned
);
  logic [31:0] off;
  logic [31:0] word_off;

  assign off      = addr - BASE_ADDR;
  assign word_off = off / WORD_BYTES;
  assign idx      = word_off[IDX_W-1:0];
  // addr >= BASE_ADDR guards against the subtraction wrapping below the base
  assign in_range = (addr >= BASE_ADDR) && (word_off < DEPTH);
  assign aligned  = (addr[1:0] == 2'b00);
endmodule

// File: rtl/riscv_mem_responder.sv
// Word-array memory serving instruction fetch, data load/store and testbench preload,
// zeroed by a hardware clear sequence after every reset.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       RST_n,
  riscv_mem_if.slave bus
);
  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      din_q, din_d;
  logic             busy_q, busy_d;
  logic             ea_q, ea_d;
  logic             er_q, er_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic [CNT_W-1:0] wc_q, wc_d;

  logic [IDX_W-1:0] i_idx, d_idx, l_idx;
  logic             i_rng, d_rng, l_rng;
  logic             i_al, d_al, l_al;

  mem_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_chk_fetch (
    .addr(bus.INSTR_ADDR), .idx(i_idx), .in_range(i_rng), .aligned(i_al)
  );
  mem_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_chk_data (
    .addr(bus.DATA_ADDR), .idx(d_idx), .in_range(d_rng), .aligned(d_al)
  );
  mem_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_chk_load (
    .addr(bus.LOAD_ADDR), .idx(l_idx), .in_range(l_rng), .aligned(l_al)
  );

  logic             rdy;
  logic             ld_ok, cw_ok, rd_ok;
  logic             we;
  logic [IDX_W-1:0] wa;
  logic [31:0]      wd;
  logic [31:0]      fetch_word, rd_word;

  assign rdy   = (state_q == READY);
  assign ld_ok = rdy & bus.LOAD_EN & l_rng & l_al;
  // a preload in the same cycle suppresses the CPU write entirely
  assign cw_ok = rdy & bus.WR_EN & ~bus.LOAD_EN & d_rng & d_al;
  assign rd_ok = rdy & bus.RD_EN & d_rng & d_al;

  assign we = ld_ok | cw_ok;
  assign wa = ld_ok ? l_idx : d_idx;
  assign wd = ld_ok ? bus.LOAD_DATA : bus.DATA_OUT;

  // write-first bypass so same-cycle readers see the data being stored
  assign fetch_word = (we && wa == i_idx) ? wd : mem[i_idx];
  assign rd_word    = (we && wa == d_idx) ? wd : mem[d_idx];

  always_ff @(posedge CLK) begin
    if (RST_n) begin
      if (state_q == CLEAR) mem[clr_idx_q] <= '0;
      else if (we)          mem[wa]        <= wd;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    instr_d   = instr_q;
    din_d     = din_q;
    ea_d      = ea_q;
    er_d      = er_q;
    rc_d      = rc_q;
    wc_d      = wc_q;
    unique case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        instr_d = i_rng ? fetch_word : NOP_INSTR;
        if (!i_rng) er_d = 1'b1;
        if (bus.LOAD_EN) begin
          if (!l_al)  ea_d = 1'b1;
          if (!l_rng) er_d = 1'b1;
        end else if (bus.WR_EN) begin
          if (!d_al)  ea_d = 1'b1;
          if (!d_rng) er_d = 1'b1;
          if (cw_ok && wc_q != {CNT_W{1'b1}}) wc_d = wc_q + 1'b1;
        end
        if (bus.RD_EN) begin
          din_d = rd_ok ? rd_word : '0;
          if (!d_al)  ea_d = 1'b1;
          if (!d_rng) er_d = 1'b1;
          if (rd_ok && rc_q != {CNT_W{1'b1}}) rc_d = rc_q + 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      instr_q   <= '0;
      din_q     <= '0;
      ea_q      <= 1'b0;
      er_q      <= 1'b0;
      rc_q      <= '0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      instr_q   <= instr_d;
      din_q     <= din_d;
      ea_q      <= ea_d;
      er_q      <= er_d;
      rc_q      <= rc_d;
      wc_q      <= wc_d;
    end
  end

  assign bus.INSTR     = instr_q;
  assign bus.DATA_IN   = din_q;
  assign bus.BUSY      = busy_q;
  assign bus.ERR_ALIGN = ea_q;
  assign bus.ERR_RANGE = er_q;
  assign bus.RD_CNT    = rc_q;
  assign bus.WR_CNT    = wc_q;
endmodule
